// File: rtl/neosd_pkg.sv
// Shared definitions for the SD data-line paths: CRC-16 constants and the
// receive FSM state encoding.
package neosd_pkg;

  localparam int CRC16_W = 16;
  localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_WAIT_START,
    RX_DATA,
    RX_CRC,
    RX_ENDBIT
  } dat_rx_state_t;

endpackage

// File: rtl/neosd_crc16_ser.sv
// Serial CRC-16-CCITT register (x^16+x^12+x^5+1, init 0, MSB first).
// Shared between the data receive and transmit paths.
module neosd_crc16_ser
  import neosd_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic [CRC16_W-1:0] crc_o,
  output logic               nonzero_o
);

  logic [CRC16_W-1:0] crc_q;
  logic               feedback;

  assign feedback = crc_q[CRC16_W-1] ^ bit_i;

  // Clear wins over enable so an abort on a strobe cycle still empties the register.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[CRC16_W-2:0], 1'b0} ^ (feedback ? CRC16_POLY : '0);
    end
  end

  assign crc_o     = crc_q;
  assign nonzero_o = |crc_q;

endmodule

// File: rtl/neosd_dat_rx.sv
// Single-lane SD data-block receiver: start-bit search with timeout, MSB-first
// byte deserialisation, CRC-16 and end-bit check.
module neosd_dat_rx
  import neosd_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int TMO_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clkstrb_i,
  input  logic             dat_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             crc_err_o,
  output logic             end_err_o,
  output logic             tmo_o
);

  localparam int BLOCK_BITS = 8 * BLOCK_BYTES;
  localparam int CNT_W      = $clog2(BLOCK_BITS + 1);

  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(BLOCK_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC_BIT  = CNT_W'(CRC16_W - 1);

  dat_rx_state_t state_q, state_d;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0] tmo_inc;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       shift_in;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             done_q, done_d;
  logic             crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d;
  logic             tmo_q, tmo_d;

  logic               crc_clr;
  logic               crc_en;
  logic [CRC16_W-1:0] crc_rem;
  logic               crc_nonzero;

  neosd_crc16_ser u_crc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (crc_clr),
    .en_i      (crc_en),
    .bit_i     (dat_i),
    .crc_o     (crc_rem),
    .nonzero_o (crc_nonzero)
  );

  assign shift_in = {shift_q[6:0], dat_i};
  assign tmo_inc  = tmo_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    done_d       = 1'b0;
    crc_err_d    = crc_err_q;
    end_err_d    = end_err_q;
    tmo_d        = tmo_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    if (abort_i) begin
      state_d   = RX_IDLE;
      bit_cnt_d = '0;
      tmo_cnt_d = '0;
      shift_d   = '0;
      crc_clr   = 1'b1;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          if (start_i) begin
            state_d   = RX_WAIT_START;
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
            tmo_d     = 1'b0;
            crc_clr   = 1'b1;
          end
        end

        RX_WAIT_START: begin
          if (clkstrb_i) begin
            if (!dat_i) begin
              state_d   = RX_DATA;
              bit_cnt_d = '0;
            end else if ((tmo_limit_i != '0) && (tmo_inc == tmo_limit_i)) begin
              state_d   = RX_IDLE;
              tmo_cnt_d = '0;
              tmo_d     = 1'b1;
              done_d    = 1'b1;
            end else if (tmo_cnt_q != '1) begin
              // Saturate so an unlimited wait never wraps the counter.
              tmo_cnt_d = tmo_inc;
            end
          end
        end

        RX_DATA: begin
          if (clkstrb_i) begin
            crc_en  = 1'b1;
            shift_d = shift_in;
            if (bit_cnt_q[2:0] == 3'd7) begin
              byte_d       = shift_in;
              byte_valid_d = 1'b1;
            end
            if (bit_cnt_q == LAST_DATA_BIT) begin
              state_d   = RX_CRC;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        RX_CRC: begin
          if (clkstrb_i) begin
            crc_en = 1'b1;
            if (bit_cnt_q == LAST_CRC_BIT) begin
              state_d   = RX_ENDBIT;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        RX_ENDBIT: begin
          if (clkstrb_i) begin
            // Data followed by its own CRC leaves a zero remainder.
            crc_err_d = crc_nonzero || (crc_rem != '0);
            end_err_d = ~dat_i;
            done_d    = 1'b1;
            state_d   = RX_IDLE;
          end
        end

        default: begin
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      crc_err_q    <= crc_err_d;
      end_err_q    <= end_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign busy_o       = (state_q != RX_IDLE);
  assign done_o       = done_q;
  assign crc_err_o    = crc_err_q;
  assign end_err_o    = end_err_q;
  assign tmo_o        = tmo_q;

endmodule

// File: doc/neosd_dat_rx.md
Name: neosd_dat_rx

Overview:
Single-lane (DAT0, 1-bit mode) SD data-block receiver. It waits for the start bit, deserialises a fixed-size block MSB-first into bytes, and checks the trailing CRC-16 and end bit. It is the receive-side counterpart of the data-line transmit path and its CRC-16 generator. The block sits between the SD pad sampling logic (which provides clkstrb_i at the card-clock sample point) and the host-side read FIFO.

Parameters:
BLOCK_BYTES, 512, data bytes per block (1..2048)
TMO_W, 16, width of the start-bit timeout counter

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
clkstrb_i  in  1  sample strobe; dat_i is evaluated only in cycles where this is 1
dat_i  in  1  DAT0 line level (already synchronised)
start_i  in  1  arm receiver for one block (1-cycle pulse)
abort_i  in  1  abandon reception, return to IDLE
tmo_limit_i  in  TMO_W  max strobes to wait for start bit
byte_o  out  8  received byte, MSB = first bit on line
byte_valid_o  out  1  1-cycle pulse, byte_o valid
busy_o  out  1  receiver armed or receiving
done_o  out  1  1-cycle pulse, block finished (success or error)
crc_err_o  out  1  CRC mismatch of last block
end_err_o  out  1  end bit was 0
tmo_o  out  1  start bit not seen within tmo_limit_i strobes

Behaviour:
- Interface fixed: one clock clk_i; reset rst_i is synchronous, active-high.
- Reset: state IDLE; byte_o=0, byte_valid_o=0, busy_o=0, done_o=0, crc_err_o=0, end_err_o=0, tmo_o=0; all counters and the CRC register are 0.
- States: IDLE, WAIT_START, DATA, CRC, ENDBIT.
- IDLE: start_i -> WAIT_START. Clear the error flags, the timeout counter and the CRC register. busy_o=1 in every state except IDLE.
- WAIT_START: on each strobe, if dat_i=0 -> DATA with bit count 0. Otherwise increment the timeout counter. When the counter equals tmo_limit_i on a strobe with dat_i=1: set tmo_o, pulse done_o, go to IDLE. tmo_limit_i=0 means no timeout.
- DATA: each strobe shifts dat_i into the byte shift register and into the CRC. After the 8th bit of a byte, byte_o/byte_valid_o are updated in the same cycle as the strobe that sampled that bit. There is no backpressure; the consumer must accept every pulse. After 8*BLOCK_BYTES bits -> CRC.
- CRC: shift 16 received CRC bits into the same CRC register. CRC-16-CCITT: polynomial x^16+x^12+x^5+1 (0x1021), init 0, MSB-first. After the 16th bit, a correct block leaves a remainder of 0 -> ENDBIT.
- ENDBIT: on the strobe, set end_err_o = ~dat_i and crc_err_o = (remainder != 0). Pulse done_o in the same cycle, then go to IDLE.
- Error flags hold until the next accepted start_i or reset.
- start_i while busy_o=1: ignored.
- abort_i: highest priority after reset. From any state go to IDLE on the next edge. No done_o, no byte_valid_o, flags unchanged. The CRC is cleared.
- Strobes in consecutive cycles are legal; the minimum strobe spacing is 1 cycle.
- The bit counter is sized clog2(8*BLOCK_BYTES+1) and must not wrap.

Decomposition:
- Package neosd_pkg: CRC16_POLY = 16'h1021, the state enum typedef for this block, and a shared CRC16 width constant.
- Sub-module neosd_crc16_ser: serial CRC-16 register.
  - Inputs: clk_i, rst_i, clr_i, en_i, bit_i.
  - Outputs: crc_o[15:0] and nonzero_o.
  - Instantiated once here. Reusable by the transmit path.

Test Plan:
- BLOCK_BYTES=512, all 0xFF, CRC bits 0x7FA1, end bit 1 -> 512 byte_valid_o pulses each 0xFF, done_o once, crc_err_o=0, end_err_o=0.
- BLOCK_BYTES=4, bytes 0x01,0x02,0x03,0x04 with the correct CRC, but one CRC bit flipped -> bytes delivered intact, crc_err_o=1 at done_o.
- Correct block with end bit 0 -> end_err_o=1, crc_err_o=0.
- tmo_limit_i=10, dat_i held 1 -> tmo_o=1 and done_o on the 10th strobe, busy_o falls, zero byte_valid_o pulses.
- abort_i asserted after byte 100 of 512 -> IDLE next cycle, no done_o. A following start_i plus a good block completes cleanly.
- Irregular strobes (gaps of 0..5 cycles), plus start_i pulsed mid-block -> identical byte stream and CRC result, second start_i ignored.
